// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Types shared by uop_fetch, uop_pair_queue and decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int MAX_PREDICT_DEPTH_BITS = 4;
    localparam int INSTR_BITS             = 32;

    typedef struct packed {
        logic [INSTR_BITS-1:0]             instr1;
        logic [INSTR_BITS-1:0]             instr2;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag1;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag2;
    } uop_pair_t;

    localparam int UOP_PAIR_BITS = $bits(uop_pair_t);

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/uop_pair_queue.sv
`default_nettype none
// ============================================================================
//  Module      : uop_pair_queue
//  Description : Flop-based circular FIFO of instruction pairs between
//                uop_fetch and decode; flushed by the pipeline clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module uop_pair_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_BITS = MAX_PREDICT_DEPTH_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       prev_valid,
    output logic                       stalled,
    input  logic [31:0]                in_instruction_1,
    input  logic [31:0]                in_instruction_2,
    input  logic [TAG_BITS-1:0]        in_branch_tag_1,
    input  logic [TAG_BITS-1:0]        in_branch_tag_2,
    output logic                       valid,
    input  logic                       next_stalled,
    output logic [31:0]                out_instruction_1,
    output logic [31:0]                out_instruction_2,
    output logic [TAG_BITS-1:0]        out_branch_tag_1,
    output logic [TAG_BITS-1:0]        out_branch_tag_2,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

    uop_pair_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_nonempty;
    logic               w_enq;
    logic               w_deq;
    uop_pair_t          w_wr_pair;
    uop_pair_t          w_head;

    // Status flags come from the count register only, so no input reaches an output.
    assign w_full     = (r_count == c_full_count);
    assign w_nonempty = (r_count != '0);
    assign w_enq      = prev_valid && !w_full;
    assign w_deq      = w_nonempty && !next_stalled;

    assign w_wr_pair.instr1 = in_instruction_1;
    assign w_wr_pair.instr2 = in_instruction_2;
    assign w_wr_pair.tag1   = in_branch_tag_1;
    assign w_wr_pair.tag2   = in_branch_tag_2;

    assign w_head = r_mem[r_rd_ptr];

    assign stalled           = w_full;
    assign valid             = w_nonempty;
    assign occupancy         = r_count;
    assign out_instruction_1 = w_head.instr1;
    assign out_instruction_2 = w_head.instr2;
    assign out_branch_tag_1  = w_head.tag1;
    assign out_branch_tag_2  = w_head.tag2;

    // Payload storage is deliberately left out of reset; the count guards it.
    always_ff @(posedge clk) begin
        if (w_enq && !clear) begin
            r_mem[r_wr_ptr] <= w_wr_pair;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uop_pair_queue
`default_nettype wire

// File: doc/uop_pair_queue.md
# uop_pair_queue

Decoupling FIFO that sits directly downstream of uop_fetch and upstream of decode. It holds up to DEPTH instruction pairs, each two 32-bit instructions plus their branch tags. It absorbs decode back-pressure so uop_fetch keeps its uop_addr stream moving, and it is emptied by the same pipeline clear.

## Interface
Parameters:
- DEPTH, 4, number of pair entries; power of two, ≥2
- TAG_BITS, MAX_PREDICT_DEPTH_BITS, branch tag width per instruction

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- clear  in  1  synchronous flush (mispredict/exception)
- prev_valid  in  1  uop_fetch has a pair on its outputs this cycle
- stalled  out  1  queue cannot accept; upstream must hold its pair
- in_instruction_1 / in_instruction_2  in  32  older / younger instruction
- in_branch_tag_1 / in_branch_tag_2  in  TAG_BITS  tags for each
- valid  out  1  head pair present on out_* ports
- next_stalled  in  1  decode refuses head this cycle
- out_instruction_1 / out_instruction_2  out  32  head pair
- out_branch_tag_1 / out_branch_tag_2  out  TAG_BITS  head tags
- occupancy  out  $clog2(DEPTH)+1  entries currently held

## Operation
- Storage: DEPTH entries {instr1, instr2, tag1, tag2}, circular, head pointer rd_ptr, tail pointer wr_ptr, both $clog2(DEPTH) bits; count register $clog2(DEPTH)+1 bits.
- stalled = (count == DEPTH); combinational from registers only, never from prev_valid or next_stalled.
- valid = (count != 0); out_* driven from entry[rd_ptr]; values are don't-care when valid=0.
- enq = prev_valid && !stalled: entry[wr_ptr] ← in_*, wr_ptr +1 (natural wrap mod DEPTH).
- deq = valid && !next_stalled: rd_ptr +1 (wrap).
- count next = count + enq − deq. When both fire, count is unchanged.
- Full: enq is impossible. A deq in the same cycle frees the slot only for the following cycle; there is no same-cycle pass-through.
- Empty: deq is impossible. A pair enqueued into an empty queue is presented the next cycle.
- clear has priority over enq/deq in its cycle: rd_ptr, wr_ptr and count go to 0. The incoming pair is dropped, and the head is not consumed by decode.
- Reset (async assert): rd_ptr=wr_ptr=count=0, so valid=0, stalled=0, occupancy=0. Entry storage is not reset. Deassertion is synchronised externally; the first edge after release behaves as normal.
- Reset asserted mid-operation discards all contents immediately. No partial-pair state exists.
- Pairs are never split. Slot order is preserved: _1 stays _1, _2 stays _2.

## Timing
- Enqueue-to-output latency: 1 cycle when empty. Otherwise the pair waits behind older entries.
- Throughput: 1 pair/cycle in and out sustained at any occupancy below DEPTH.
- stalled, valid and occupancy are registered-derived, so there are no combinational paths from any input to any output.
- clear takes effect on the next edge; valid=0 and stalled=0 in the cycle after clear.

## Structure
- Shared package (pipeline_pkg): MAX_PREDICT_DEPTH_BITS, and a uop_pair_t packed struct {instr1, instr2, tag1, tag2} reused by uop_fetch and decode.
- Storage is one array of uop_pair_t, flop-based. At DEPTH ≤ 8, no RAM macro is used.
- No sub-module; pointer/count logic is inline.

## Test plan
- Reset: hold reset=0 for 3 cycles with prev_valid=1 → valid=0, stalled=0, occupancy=0 throughout. After release, the first pair (0x11111111, 0x22222222, tags 1, 2) appears on out_* exactly 1 cycle after enqueue.
- Fill/back-pressure: next_stalled=1, push pairs A,B,C,D (DEPTH=4) → stalled=1 after the 4th edge and occupancy=4. A 5th pair held on the inputs is not taken. Release next_stalled → A,B,C,D drain in order, then the held 5th pair follows.
- Streaming: prev_valid=1 and next_stalled=0 for 20 cycles with incrementing instructions → one pair out per cycle, no gaps, no reordering, occupancy stays 1.
- Simultaneous enq/deq at count=2 → count stays 2 and the head advances by one.
- Wrap-around: 10 alternating push/pop bursts crossing the pointer wrap → output sequence equals input sequence.
- Clear: 3 entries held, clear=1 together with prev_valid=1 and next_stalled=0 → next cycle valid=0, occupancy=0, and neither the incoming nor the head pair is ever delivered. A new pair after clear appears 1 cycle later.
